fa8_word_sequencer: RTL

//  Controller that sequences one shared 8-bit full adder (FA8) to add wide operands

---
 rtl/fa8_word_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/fa8_word_sequencer.sv
// Byte-serial wide adder controller: drives one external 8-bit full adder LSB-first,
// chaining its carry, and registers the W-bit result with carry and signed-overflow flags.
module fa8_word_sequencer #(
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [8*WORDS-1:0] a,
    input  logic [8*WORDS-1:0] b,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [8*WORDS-1:0] sum,
    output logic               cout,
    output logic               ovf,
    output logic [7:0]         adder_a,
    output logic [7:0]         adder_b,
    output logic               adder_ci,
    input  logic [7:0]         adder_y,
    input  logic               adder_co
);

    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q;
    logic [IdxW-1:0]         idx_q;
    logic                    carry_q;
    logic [WORDS-1:0][7:0]   a_q;
    logic [WORDS-1:0][7:0]   b_q;
    logic [WORDS-1:0][7:0]   work_q;
    logic [WORDS-1:0][7:0]   work_merged;

    // The adder is combinational, so its inputs must be valid in the same RUN cycle.
    always_comb begin
        work_merged         = work_q;
        work_merged[idx_q]  = adder_y;
        adder_a             = '0;
        adder_b             = '0;
        adder_ci            = 1'b0;
        if (state_q == StRun) begin
            adder_a  = a_q[idx_q];
            adder_b  = b_q[idx_q];
            adder_ci = carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    work_q  <= work_merged;
                    carry_q <= adder_co;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        // Final byte is the top byte, so adder_y[7] is the new sum MSB.
                        state_q <= StDone;
                        idx_q   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        sum     <= work_merged;
                        cout    <= adder_co;
                        ovf     <= (a_q[WORDS-1][7] == b_q[WORDS-1][7]) &&
                                   (adder_y[7] != a_q[WORDS-1][7]);
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
